mem_arbiter: RTL and testbench

Two-port arbiter that shares one cache/memory subsystem between the instruction-fetch port and the data port of the pipeline. The arbiter selects one requester, captures its request into hold registers, and holds it stable on the downstream port until the cache controller returns Done. It then steers Done, CacheHit and DataOut back to the winning port. It sits between the fetch/memory stages and the memory subsystem, which expects Addr, DataIn, Rd and Wr stable for the whole transaction.

---
 rtl/mem_arbiter_if.sv | 47 ++++
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and cache-controller-side signals around mem_arbiter.
// The arbiter uses the slave view; whatever drives requests and models memory uses master.
interface mem_arbiter_if;
   logic [15:0] i_Addr;
   logic        i_Rd;
   logic [15:0] d_Addr;
   logic [15:0] d_DataIn;
   logic        d_Rd;
   logic        d_Wr;
   logic        createdump;

   logic [15:0] i_DataOut;
   logic        i_Done;
   logic        i_Stall;
   logic        i_CacheHit;
   logic [15:0] d_DataOut;
   logic        d_Done;
   logic        d_Stall;
   logic        d_CacheHit;
   logic        err;

   logic [15:0] mem_Addr;
   logic [15:0] mem_DataIn;
   logic        mem_Rd;
   logic        mem_Wr;
   logic        mem_createdump;
   logic [15:0] mem_DataOut;
   logic        mem_Done;
   logic        mem_CacheHit;
   logic        mem_Stall;

   modport slave (
      input  i_Addr, i_Rd, d_Addr, d_DataIn, d_Rd, d_Wr, createdump,
      input  mem_DataOut, mem_Done, mem_CacheHit, mem_Stall,
      output i_DataOut, i_Done, i_Stall, i_CacheHit,
      output d_DataOut, d_Done, d_Stall, d_CacheHit, err,
      output mem_Addr, mem_DataIn, mem_Rd, mem_Wr, mem_createdump
   );

   modport master (
      output i_Addr, i_Rd, d_Addr, d_DataIn, d_Rd, d_Wr, createdump,
      output mem_DataOut, mem_Done, mem_CacheHit, mem_Stall,
      input  i_DataOut, i_Done, i_Stall, i_CacheHit,
      input  d_DataOut, d_Done, d_Stall, d_CacheHit, err,
      input  mem_Addr, mem_DataIn, mem_Rd, mem_Wr, mem_createdump
   );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one cache controller between the instruction-fetch and data ports.
// The granted request is frozen in hold registers until the controller returns Done.
module mem_arbiter #(
   parameter int DATA_PRIORITY = 0
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus_io
);

   typedef enum logic {IDLE, BUSY} state_t;
   typedef enum logic {PORT_I, PORT_D} port_t;

   state_t      state_q, state_d;
   port_t       winner_q, winner_d;
   port_t       lastGrant_q, lastGrant_d;
   logic [15:0] holdAddr_q, holdAddr_d;
   logic [15:0] holdData_q, holdData_d;
   logic        holdRd_q, holdRd_d;
   logic        holdWr_q, holdWr_d;

   logic iReq;
   logic dReq;
   logic dIllegal;
   logic grantData;
   logic busy;
   logic doneNow;

   // A data request with both strobes high is not a request at all for arbitration.
   assign dIllegal  = bus_io.d_Rd & bus_io.d_Wr;
   assign dReq      = bus_io.d_Rd ^ bus_io.d_Wr;
   assign iReq      = bus_io.i_Rd;
   assign grantData = dReq & (~iReq | (DATA_PRIORITY != 0) | (lastGrant_q == PORT_I));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         winner_q    <= PORT_I;
         lastGrant_q <= PORT_I;
         holdAddr_q  <= '0;
         holdData_q  <= '0;
         holdRd_q    <= 1'b0;
         holdWr_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         winner_q    <= winner_d;
         lastGrant_q <= lastGrant_d;
         holdAddr_q  <= holdAddr_d;
         holdData_q  <= holdData_d;
         holdRd_q    <= holdRd_d;
         holdWr_q    <= holdWr_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      winner_d    = winner_q;
      lastGrant_d = lastGrant_q;
      holdAddr_d  = holdAddr_q;
      holdData_d  = holdData_q;
      holdRd_d    = holdRd_q;
      holdWr_d    = holdWr_q;
      case (state_q)
         IDLE: begin
            if (iReq || dReq) begin
               state_d = BUSY;
               if (grantData) begin
                  winner_d   = PORT_D;
                  holdAddr_d = bus_io.d_Addr;
                  holdData_d = bus_io.d_DataIn;
                  holdRd_d   = bus_io.d_Rd;
                  holdWr_d   = bus_io.d_Wr;
               end else begin
                  winner_d   = PORT_I;
                  holdAddr_d = bus_io.i_Addr;
                  holdData_d = '0;
                  holdRd_d   = 1'b1;
                  holdWr_d   = 1'b0;
               end
            end
         end
         BUSY: begin
            if (bus_io.mem_Done) begin
               state_d     = IDLE;
               lastGrant_d = winner_q;
            end
         end
      endcase
   end

   // Everything visible is forced quiet while rst is high so a reset cycle never leaks a Done.
   assign busy    = (state_q == BUSY) & ~rst;
   assign doneNow = busy & bus_io.mem_Done;

   assign bus_io.mem_Addr       = holdAddr_q;
   assign bus_io.mem_DataIn     = holdData_q;
   assign bus_io.mem_Rd         = busy & holdRd_q;
   assign bus_io.mem_Wr         = busy & holdWr_q;
   assign bus_io.mem_createdump = bus_io.createdump;

   assign bus_io.i_Done     = doneNow & (winner_q == PORT_I);
   assign bus_io.i_DataOut  = bus_io.i_Done ? bus_io.mem_DataOut : 16'h0000;
   assign bus_io.i_CacheHit = bus_io.i_Done & bus_io.mem_CacheHit;
   assign bus_io.i_Stall    = iReq & ~bus_io.i_Done & ~rst;

   assign bus_io.d_Done     = doneNow & (winner_q == PORT_D);
   assign bus_io.d_DataOut  = bus_io.d_Done ? bus_io.mem_DataOut : 16'h0000;
   assign bus_io.d_CacheHit = bus_io.d_Done & bus_io.mem_CacheHit;
   assign bus_io.d_Stall    = dReq & ~bus_io.d_Done & ~rst;

   assign bus_io.err = dIllegal & ~rst;

   // Controller protocol checks: no Done while idle, and never Done while claiming a stall.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(state_q == IDLE && bus_io.mem_Done));
         assert (!(bus_io.mem_Done && bus_io.mem_Stall));
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Drives two arbiters (round-robin and data-priority) side by side and compares every
// output each cycle with a transaction-level model of grant order and memory latency.
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_arbiter_if bus [2] ();

   logic        iRd [2], dRd [2], dWr [2], cDump [2];
   logic        mDone [2], mHit [2], mStall [2];
   logic [15:0] iAddr [2], dAddr [2], dData [2], mData [2];

   logic        oIDone [2], oIStall [2], oIHit [2];
   logic        oDDone [2], oDStall [2], oDHit [2];
   logic        oErr [2], oMRd [2], oMWr [2], oMDump [2];
   logic [15:0] oIData [2], oDData [2], oMAddr [2], oMDataIn [2];

   for (genvar g = 0; g < 2; g++) begin : gDut
      mem_arbiter #(.DATA_PRIORITY(g)) dut (
         .clk    (clk),
         .rst    (rst),
         .bus_io (bus[g])
      );
      assign bus[g].i_Addr       = iAddr[g];
      assign bus[g].i_Rd         = iRd[g];
      assign bus[g].d_Addr       = dAddr[g];
      assign bus[g].d_DataIn     = dData[g];
      assign bus[g].d_Rd         = dRd[g];
      assign bus[g].d_Wr         = dWr[g];
      assign bus[g].createdump   = cDump[g];
      assign bus[g].mem_DataOut  = mData[g];
      assign bus[g].mem_Done     = mDone[g];
      assign bus[g].mem_CacheHit = mHit[g];
      assign bus[g].mem_Stall    = mStall[g];
      assign oIDone[g]   = bus[g].i_Done;
      assign oIStall[g]  = bus[g].i_Stall;
      assign oIHit[g]    = bus[g].i_CacheHit;
      assign oIData[g]   = bus[g].i_DataOut;
      assign oDDone[g]   = bus[g].d_Done;
      assign oDStall[g]  = bus[g].d_Stall;
      assign oDHit[g]    = bus[g].d_CacheHit;
      assign oDData[g]   = bus[g].d_DataOut;
      assign oErr[g]     = bus[g].err;
      assign oMRd[g]     = bus[g].mem_Rd;
      assign oMWr[g]     = bus[g].mem_Wr;
      assign oMAddr[g]   = bus[g].mem_Addr;
      assign oMDataIn[g] = bus[g].mem_DataIn;
      assign oMDump[g]   = bus[g].mem_createdump;
   end

   int assertCnt = 0;
   int failCnt   = 0;
   int cyc       = 0;
   bit          randomMode;
   int          dirLat;
   logic [15:0] respData;

   // Requester intent and the model's view of who owns the memory and for how long.
   bit          iPend [2], dPend [2], dIsWr [2], dIll [2];
   int          dIllCnt [2];
   bit          mBusy [2], mOwner [2], mLast [2];
   logic [15:0] hAddr [2], hData [2];
   bit          hRd [2], hWr [2];
   int          memCnt [2], memLat [2];
   logic [15:0] orderBits [2];
   int          orderLen [2];

   logic        sIDone [2], sIHit [2], sIStall [2], sDDone [2], sDStall [2];
   logic        sErr [2], sMRd [2], sMWr [2];
   logic [15:0] sIData [2], sMAddr [2], sMDataIn [2];

   task automatic expectBit(string tag, int sel, logic obs, logic exp);
      assertCnt++;
      assert (obs === exp) else begin
         failCnt++;
         $error("[TB] FAIL %s dut%0d: observed %b expected %b", tag, sel, obs, exp);
      end
   endtask

   task automatic expectWord(string tag, int sel, logic [15:0] obs, logic [15:0] exp);
      assertCnt++;
      assert (obs === exp) else begin
         failCnt++;
         $error("[TB] FAIL %s dut%0d: observed %h expected %h", tag, sel, obs, exp);
      end
   endtask

   task automatic applyStimulus(int sel);
      cDump[sel] = 1'($urandom_range(0, 1));
      if (randomMode && !rst) begin
         if (!iPend[sel] && $urandom_range(0, 3) == 0) begin
            iPend[sel] = 1'b1;
            iAddr[sel] = 16'($urandom);
         end
         if (!dPend[sel] && !dIll[sel] && $urandom_range(0, 3) == 0) begin
            dAddr[sel] = 16'($urandom);
            dData[sel] = 16'($urandom);
            if ($urandom_range(0, 7) == 0) begin
               dIll[sel]    = 1'b1;
               dIllCnt[sel] = int'($urandom_range(1, 3));
            end else begin
               dPend[sel] = 1'b1;
               dIsWr[sel] = 1'($urandom_range(0, 1));
            end
         end
      end
      iRd[sel] = iPend[sel];
      dRd[sel] = dIll[sel] | (dPend[sel] & ~dIsWr[sel]);
      dWr[sel] = dIll[sel] | (dPend[sel] & dIsWr[sel]);
      mDone[sel]  = !rst && mBusy[sel] && (memCnt[sel] == memLat[sel]);
      mData[sel]  = randomMode ? 16'($urandom) : respData;
      mHit[sel]   = randomMode ? 1'($urandom_range(0, 1)) : 1'b1;
      mStall[sel] = mBusy[sel] && !mDone[sel];
   endtask

   task automatic checkOutput(int sel);
      bit          doneNow, eIDone, eDDone;
      logic [15:0] eIData, eDData;
      doneNow = mBusy[sel] && mDone[sel];
      eIDone  = doneNow && (mOwner[sel] == 1'b0);
      eDDone  = doneNow && (mOwner[sel] == 1'b1);
      eIData  = eIDone ? mData[sel] : 16'h0000;
      eDData  = eDDone ? mData[sel] : 16'h0000;
      expectBit ("i_Done",     sel, oIDone[sel],  eIDone);
      expectWord("i_DataOut",  sel, oIData[sel],  eIData);
      expectBit ("i_CacheHit", sel, oIHit[sel],   eIDone & mHit[sel]);
      expectBit ("i_Stall",    sel, oIStall[sel], iRd[sel] & ~eIDone);
      expectBit ("d_Done",     sel, oDDone[sel],  eDDone);
      expectWord("d_DataOut",  sel, oDData[sel],  eDData);
      expectBit ("d_CacheHit", sel, oDHit[sel],   eDDone & mHit[sel]);
      expectBit ("d_Stall",    sel, oDStall[sel], (dRd[sel] ^ dWr[sel]) & ~eDDone);
      expectBit ("err",        sel, oErr[sel],    dRd[sel] & dWr[sel]);
      expectBit ("mem_Rd",     sel, oMRd[sel],    mBusy[sel] & hRd[sel]);
      expectBit ("mem_Wr",     sel, oMWr[sel],    mBusy[sel] & hWr[sel]);
      expectBit ("mem_createdump", sel, oMDump[sel], cDump[sel]);
      if (mBusy[sel]) begin
         expectWord("mem_Addr",   sel, oMAddr[sel],   hAddr[sel]);
         expectWord("mem_DataIn", sel, oMDataIn[sel], hData[sel]);
      end
      sIDone[sel]  = oIDone[sel];
      sIHit[sel]   = oIHit[sel];
      sIStall[sel] = oIStall[sel];
      sDDone[sel]  = oDDone[sel];
      sDStall[sel] = oDStall[sel];
      sErr[sel]    = oErr[sel];
      sMRd[sel]    = oMRd[sel];
      sMWr[sel]    = oMWr[sel];
      sIData[sel]  = oIData[sel];
      sMAddr[sel]  = oMAddr[sel];
      sMDataIn[sel] = oMDataIn[sel];
   endtask

   // Advances the reference model by one clock using the inputs the DUT just sampled.
   task automatic updateModel(int sel);
      bit iWant, dWant, w;
      if (rst) begin
         mBusy[sel]  = 1'b0;
         mLast[sel]  = 1'b0;
         memCnt[sel] = 0;
      end else if (mBusy[sel]) begin
         if (mDone[sel]) begin
            mBusy[sel]     = 1'b0;
            mLast[sel]     = mOwner[sel];
            orderBits[sel] = {orderBits[sel][14:0], mOwner[sel]};
            orderLen[sel]++;
            if (mOwner[sel]) dPend[sel] = 1'b0;
            else             iPend[sel] = 1'b0;
         end else begin
            memCnt[sel]++;
         end
      end else begin
         iWant = iRd[sel];
         dWant = dRd[sel] ^ dWr[sel];
         if (iWant || dWant) begin
            if (iWant && dWant) w = (sel == 1) ? 1'b1 : ~mLast[sel];
            else                w = dWant;
            mOwner[sel] = w;
            hAddr[sel]  = w ? dAddr[sel] : iAddr[sel];
            hData[sel]  = w ? dData[sel] : 16'h0000;
            hRd[sel]    = w ? dRd[sel] : 1'b1;
            hWr[sel]    = w ? dWr[sel] : 1'b0;
            mBusy[sel]  = 1'b1;
            memCnt[sel] = 0;
            memLat[sel] = randomMode ? int'($urandom_range(0, 4)) : dirLat;
         end
      end
      if (dIll[sel]) begin
         dIllCnt[sel]--;
         if (dIllCnt[sel] <= 0) dIll[sel] = 1'b0;
      end
   endtask

   task automatic cycle();
      for (int s = 0; s < 2; s++) applyStimulus(s);
      #1;
      if (!rst) for (int s = 0; s < 2; s++) checkOutput(s);
      @(posedge clk);
      for (int s = 0; s < 2; s++) updateModel(s);
      @(negedge clk);
      cyc++;
   endtask

   function automatic bit anyActive();
      bit a = 1'b0;
      for (int s = 0; s < 2; s++) a |= iPend[s] | dPend[s] | dIll[s] | mBusy[s];
      return a;
   endfunction

   task automatic runUntilIdle(int budget, string tag);
      int n = 0;
      while (anyActive() && n < budget) begin
         cycle();
         n++;
      end
      assertCnt++;
      assert (n < budget) else begin
         failCnt++;
         $error("[TB] FAIL %s: observed %0d cycles expected fewer than %0d", tag, n, budget);
      end
   endtask

   task automatic raiseI(int sel, logic [15:0] a);
      iPend[sel] = 1'b1;
      iAddr[sel] = a;
   endtask

   task automatic raiseD(int sel, logic [15:0] a, logic [15:0] d, bit wr);
      dPend[sel] = 1'b1;
      dIsWr[sel] = wr;
      dAddr[sel] = a;
      dData[sel] = d;
   endtask

   task automatic clearOrder();
      for (int s = 0; s < 2; s++) begin
         orderBits[s] = 16'h0000;
         orderLen[s]  = 0;
      end
   endtask

   initial begin
      int  dDoneCyc, iIssueCyc, n;
      bit  reRaised [2];
      rst = 1'b1;
      randomMode = 1'b0;
      dirLat = 3;
      respData = 16'hBEEF;
      for (int s = 0; s < 2; s++) begin
         iPend[s] = 0; dPend[s] = 0; dIsWr[s] = 0; dIll[s] = 0; dIllCnt[s] = 0;
         mBusy[s] = 0; mOwner[s] = 0; mLast[s] = 0; memCnt[s] = 0; memLat[s] = 0;
         hAddr[s] = 0; hData[s] = 0; hRd[s] = 0; hWr[s] = 0;
         iAddr[s] = 0; dAddr[s] = 0; dData[s] = 0;
      end
      clearOrder();

      cycle();
      cycle();
      rst = 1'b0;
      cycle();
      for (int s = 0; s < 2; s++) begin
         expectWord("reset_mem_Addr", s, sMAddr[s], 16'h0000);
         expectWord("reset_mem_DataIn", s, sMDataIn[s], 16'h0000);
         expectBit ("reset_mem_Rd", s, sMRd[s], 1'b0);
         expectBit ("reset_i_Stall", s, sIStall[s], 1'b0);
      end

      $display("[TB] single read");
      for (int s = 0; s < 2; s++) raiseI(s, 16'h1234);
      cycle();
      cycle();
      for (int s = 0; s < 2; s++) begin
         expectBit ("read_issue_rd", s, sMRd[s], 1'b1);
         expectWord("read_issue_addr", s, sMAddr[s], 16'h1234);
      end
      cycle();
      cycle();
      cycle();
      for (int s = 0; s < 2; s++) begin
         expectBit ("read_done", s, sIDone[s], 1'b1);
         expectWord("read_data", s, sIData[s], 16'hBEEF);
         expectBit ("read_hit", s, sIHit[s], 1'b1);
      end
      cycle();
      for (int s = 0; s < 2; s++) expectBit("read_rd_drop", s, sMRd[s], 1'b0);

      $display("[TB] tie after reset");
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      clearOrder();
      for (int s = 0; s < 2; s++) begin
         raiseI(s, 16'h0100);
         raiseD(s, 16'h0040, 16'h5A5A, 1'b1);
      end
      cycle();
      cycle();
      for (int s = 0; s < 2; s++) begin
         expectBit ("tie_data_wr", s, sMWr[s], 1'b1);
         expectWord("tie_data_din", s, sMDataIn[s], 16'h5A5A);
         expectBit ("tie_i_stall", s, sIStall[s], 1'b1);
      end
      dDoneCyc = -1;
      iIssueCyc = -1;
      n = 0;
      while (anyActive() && n < 40) begin
         cycle();
         n++;
         if (sDDone[0]) dDoneCyc = cyc;
         else if (dDoneCyc >= 0 && iIssueCyc < 0 && sMRd[0]) iIssueCyc = cyc;
      end
      expectWord("tie_reissue_gap", 0, 16'(iIssueCyc - dDoneCyc), 16'd2);
      for (int s = 0; s < 2; s++) begin
         expectWord("tie_order_len", s, 16'(orderLen[s]), 16'd2);
         expectWord("tie_order", s, orderBits[s], 16'b10);
      end

      $display("[TB] repeated tie");
      clearOrder();
      for (int s = 0; s < 2; s++) begin
         raiseI(s, 16'h0200);
         raiseD(s, 16'h0300, 16'h0000, 1'b0);
         reRaised[s] = 1'b0;
      end
      n = 0;
      while (anyActive() && n < 60) begin
         cycle();
         n++;
         for (int s = 0; s < 2; s++) begin
            if (!dPend[s] && !reRaised[s]) begin
               raiseD(s, 16'h0310, 16'h0000, 1'b0);
               reRaised[s] = 1'b1;
            end
         end
      end
      expectWord("retie_order", 0, orderBits[0], 16'b101);
      expectWord("retie_order", 1, orderBits[1], 16'b110);

      $display("[TB] three consecutive ties");
      clearOrder();
      for (int k = 0; k < 3; k++) begin
         for (int s = 0; s < 2; s++) begin
            raiseI(s, 16'(16'h0400 + k));
            raiseD(s, 16'(16'h0500 + k), 16'(16'h0A00 + k), k[0]);
         end
         runUntilIdle(60, "tie3_timeout");
      end
      expectWord("tie3_order", 0, orderBits[0], 16'b010101);
      expectWord("tie3_order", 1, orderBits[1], 16'b101010);

      $display("[TB] hold registers stable");
      for (int s = 0; s < 2; s++) raiseI(s, 16'h2222);
      cycle();
      cycle();
      for (int s = 0; s < 2; s++) raiseD(s, 16'h3333, 16'h0000, 1'b0);
      cycle();
      for (int s = 0; s < 2; s++) dAddr[s] = 16'h4444;
      cycle();
      for (int s = 0; s < 2; s++) begin
         expectWord("held_addr", s, sMAddr[s], 16'h2222);
         expectBit ("held_rd", s, sMRd[s], 1'b1);
      end
      runUntilIdle(40, "held_timeout");

      $display("[TB] illegal data request");
      for (int s = 0; s < 2; s++) begin
         dIll[s] = 1'b1;
         dIllCnt[s] = 3;
         dAddr[s] = 16'h0ABC;
      end
      cycle();
      for (int s = 0; s < 2; s++) begin
         expectBit("illegal_err", s, sErr[s], 1'b1);
         expectBit("illegal_rd", s, sMRd[s], 1'b0);
         expectBit("illegal_wr", s, sMWr[s], 1'b0);
         expectBit("illegal_stall", s, sDStall[s], 1'b0);
      end
      runUntilIdle(20, "illegal_timeout");

      $display("[TB] reset mid-transaction");
      dirLat = 6;
      for (int s = 0; s < 2; s++) raiseI(s, 16'h5555);
      cycle();
      cycle();
      cycle();
      rst = 1'b1;
      for (int s = 0; s < 2; s++) iPend[s] = 1'b0;
      cycle();
      rst = 1'b0;
      cycle();
      for (int s = 0; s < 2; s++) begin
         expectBit ("midrst_rd", s, sMRd[s], 1'b0);
         expectBit ("midrst_i_done", s, sIDone[s], 1'b0);
         expectBit ("midrst_d_done", s, sDDone[s], 1'b0);
         expectWord("midrst_addr", s, sMAddr[s], 16'h0000);
      end
      dirLat = 3;
      clearOrder();
      for (int s = 0; s < 2; s++) begin
         raiseI(s, 16'h0600);
         raiseD(s, 16'h0700, 16'h1111, 1'b1);
      end
      runUntilIdle(40, "midrst_tie_timeout");
      for (int s = 0; s < 2; s++) expectWord("midrst_tie_order", s, orderBits[s], 16'b10);

      $display("[TB] random traffic");
      randomMode = 1'b1;
      repeat (600) cycle();
      randomMode = 1'b0;
      runUntilIdle(100, "drain_timeout");

      $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
      $finish;
   end

endmodule
